// File: rtl/branch_pred_table.sv
// ---------------------------------------------------------------------------
// branch_pred_table
//
// Branch direction predictor for the pipelined LEGv8 core. The table holds
// 2^IDX_W saturating CTR_W-bit counters. Each counter is indexed by the
// word-aligned fetch PC. When HIST_W > 0, the index is also XORed with a
// global history register (gshare). When HIST_W = 0, the table is a plain
// bimodal predictor.
//
// The lookup is made in fetch. The prediction is registered and appears one
// cycle later. The table index used travels down the pipe with the
// prediction and comes back on upd_idx when the branch resolves. The
// counter at that index is then trained.
//
// A saturating mispredict counter records every resolved branch where the
// predicted and actual directions differ.
//
// Parameters
//   PC_W    program counter width
//   IDX_W   table index width (depth = 2^IDX_W)
//   CTR_W   counter width per entry; the predictor says taken when the MSB is 1
//   HIST_W  global history bits (0 = bimodal, 1..IDX_W = gshare)
//   MISS_W  mispredict counter width
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset       synchronous, active-low reset
//   lookup_en   request a prediction for lookup_pc this cycle
//   lookup_pc   fetch PC of the branch
//   pred_valid  registered: a prediction is available (1 cycle after lookup_en)
//   pred_taken  registered: predicted direction
//   pred_idx    registered: table index used for the prediction
//   upd_en      a conditional branch resolved this cycle
//   upd_idx     index that was returned with the prediction
//   upd_taken   actual branch outcome
//   upd_guess   direction that was predicted for this branch
//   ghr         global history register (1 bit wide and tied to 0 when bimodal)
//   miss_cnt    saturating count of resolved mispredicts
// ---------------------------------------------------------------------------
module branch_pred_table #(
    parameter int PC_W   = 64,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 0,
    parameter int MISS_W = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   lookup_en,
    input  logic [PC_W-1:0]                        lookup_pc,
    output logic                                   pred_valid,
    output logic                                   pred_taken,
    output logic [IDX_W-1:0]                       pred_idx,
    input  logic                                   upd_en,
    input  logic [IDX_W-1:0]                       upd_idx,
    input  logic                                   upd_taken,
    input  logic                                   upd_guess,
    output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] ghr,
    output logic [MISS_W-1:0]                      miss_cnt
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int GHR_W = (HIST_W > 0) ? HIST_W : 1;

    // Reset value of every counter: the weakest "taken" state (MSB set, rest clear).
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // The counters are kept in flip-flops rather than block RAM. All
    // entries must return to the weakly-taken value in a single reset
    // cycle, and a block RAM cannot be cleared that way.
    logic [CTR_W-1:0]  ctr_reg [DEPTH];
    logic [GHR_W-1:0]  ghr_reg;
    logic [GHR_W-1:0]  ghr_next;
    logic              pred_valid_reg;
    logic              pred_taken_reg;
    logic [IDX_W-1:0]  pred_idx_reg;
    logic [MISS_W-1:0] miss_cnt_reg;
    logic [MISS_W-1:0] miss_cnt_next;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lookup_idx;
    logic [CTR_W-1:0] upd_ctr;
    logic [CTR_W-1:0] upd_ctr_next;
    logic [CTR_W-1:0] lookup_ctr;
    logic             upd_hits_lookup;
    logic             mispredict;

    // PC bits [1:0] are always zero for aligned instructions. The bits above
    // the index field do not take part in the index. Both groups are folded
    // into one signal so that their non-use is explicit.
    logic unused_pc_bits;
    generate
        if (PC_W > IDX_W + 2) begin : g_pc_upper
            assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};
        end else begin : g_pc_exact
            assign unused_pc_bits = ^lookup_pc[1:0];
        end
    endgenerate

    // In bimodal mode, ghr_reg is held at zero, so the XOR below is a no-op.
    // The index uses the history value from before any same-cycle update.
    assign lookup_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_reg);

    // There is one read port for the training path. Only the addressed
    // entry is ever rewritten.
    assign upd_ctr = ctr_reg[upd_idx];

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != {CTR_W{1'b1}}) begin
                upd_ctr_next = upd_ctr + 1'b1;
            end
        end else begin
            if (upd_ctr != {CTR_W{1'b0}}) begin
                upd_ctr_next = upd_ctr - 1'b1;
            end
        end
    end

    // A lookup can hit the entry that is being trained in the same cycle.
    // In that case the lookup sees the freshly trained value, so the
    // prediction never uses a stale counter.
    assign upd_hits_lookup = upd_en && (upd_idx == lookup_idx);

    always_comb begin
        lookup_ctr = ctr_reg[lookup_idx];
        if (upd_hits_lookup) begin
            lookup_ctr = upd_ctr_next;
        end
    end

    // Global history shift. The newest outcome enters at bit 0.
    generate
        if (HIST_W == 0) begin : g_bimodal
            assign ghr_next = '0;
        end else if (HIST_W == 1) begin : g_hist_one
            assign ghr_next = upd_taken;
        end else begin : g_hist_multi
            assign ghr_next = {ghr_reg[GHR_W-2:0], upd_taken};
        end
    endgenerate

    assign mispredict = (upd_guess != upd_taken);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        miss_cnt_next = miss_cnt_reg;
        if (mispredict && (miss_cnt_reg != {MISS_W{1'b1}})) begin
            miss_cnt_next = miss_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Counter table: one register per entry. An entry changes only when
    // it is the one addressed by the update.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!reset) begin
                    ctr_reg[gi] <= CTR_INIT;
                end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                    ctr_reg[gi] <= upd_ctr_next;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Prediction pipeline register, history and mispredict counter.
    // Reset discards any prediction that is in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_idx_reg   <= '0;
            ghr_reg        <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            if (lookup_en) begin
                pred_valid_reg <= 1'b1;
                pred_taken_reg <= lookup_ctr[CTR_W-1];
                pred_idx_reg   <= lookup_idx;
            end else begin
                // pred_taken and pred_idx keep their last values.
                pred_valid_reg <= 1'b0;
            end

            if (upd_en) begin
                ghr_reg      <= ghr_next;
                miss_cnt_reg <= miss_cnt_next;
            end
        end
    end

    assign pred_valid = pred_valid_reg;
    assign pred_taken = pred_taken_reg;
    assign pred_idx   = pred_idx_reg;
    assign ghr        = ghr_reg;
    assign miss_cnt   = miss_cnt_reg;

endmodule
